// File: rtl/color_pkg.sv
// Shared color definitions: mixer state codes, RGB drive patterns and the
// stepper FSM encoding.
package color_pkg;

  typedef logic [2:0] color_state_t;

  localparam color_state_t IDLE_S    = 3'b000;
  localparam color_state_t RED_S     = 3'b001;
  localparam color_state_t GREEN_S   = 3'b010;
  localparam color_state_t BLUE_S    = 3'b011;
  localparam color_state_t YELLOW_S  = 3'b100;
  localparam color_state_t CYAN_S    = 3'b101;
  localparam color_state_t MAGENTA_S = 3'b110;
  localparam color_state_t WHITE_S   = 3'b111;

  // RGB bit order is {red, green, blue}.
  localparam logic [2:0] RGB_OFF     = 3'b000;
  localparam logic [2:0] RGB_RED     = 3'b100;
  localparam logic [2:0] RGB_GREEN   = 3'b010;
  localparam logic [2:0] RGB_BLUE    = 3'b001;
  localparam logic [2:0] RGB_YELLOW  = 3'b110;
  localparam logic [2:0] RGB_CYAN    = 3'b011;
  localparam logic [2:0] RGB_MAGENTA = 3'b101;
  localparam logic [2:0] RGB_WHITE   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_PRESS,
    ST_RELEASE,
    ST_DONE,
    ST_ERR
  } stepper_state_t;

endpackage

// File: rtl/color_stepper_pulse_timer.sv
// Loadable down-counter shared by the press and release phases; zero_o flags
// the last cycle of the loaded interval.
module pulse_timer
  import color_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/color_stepper.sv
// Closed-loop button presser: pulses step_o until the mixer reports the
// requested state, giving up after NUM_STATES presses without a match.
module color_stepper
  import color_pkg::*;
#(
  parameter int NUM_STATES     = 8,
  parameter int PRESS_CYCLES   = 16,
  parameter int RELEASE_CYCLES = 16,
  parameter int CNT_W          = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go_i,
  input  color_state_t target_i,
  input  color_state_t state_i,
  output logic         step_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic [3:0]   steps_o
);

  localparam logic [3:0]       NUM_W        = 4'(NUM_STATES);
  localparam logic [CNT_W-1:0] PRESS_LOAD   = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LOAD = CNT_W'(RELEASE_CYCLES - 1);

  stepper_state_t   state_q, state_d;
  color_state_t     target_q, target_d;
  logic [3:0]       steps_q, steps_d;
  logic             err_q, err_d;
  logic             step_q;
  logic             timer_load, timer_en, timer_zero;
  logic [CNT_W-1:0] timer_val;

  pulse_timer #(.CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (timer_load),
    .load_val_i(timer_val),
    .en_i      (timer_en),
    .zero_o    (timer_zero)
  );

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    steps_d    = steps_q;
    err_d      = err_q;
    timer_load = 1'b0;
    timer_val  = PRESS_LOAD;
    timer_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go_i) begin
          target_d = target_i;
          steps_d  = '0;
          err_d    = 1'b0;
          if ({1'b0, target_i} >= NUM_W) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        // Stepping only ever moves forward; wrap-around is the mixer's job.
        if (state_i == target_q) begin
          state_d = ST_DONE;
        end else if (steps_q == NUM_W) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          state_d    = ST_PRESS;
          steps_d    = steps_q + 4'd1;
          timer_load = 1'b1;
          timer_val  = PRESS_LOAD;
        end
      end
      ST_PRESS: begin
        timer_en = 1'b1;
        if (timer_zero) begin
          state_d    = ST_RELEASE;
          timer_load = 1'b1;
          timer_val  = RELEASE_LOAD;
        end
      end
      ST_RELEASE: begin
        timer_en = 1'b1;
        if (timer_zero) begin
          state_d = ST_CHECK;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      steps_q  <= '0;
      err_q    <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      steps_q  <= steps_d;
      err_q    <= err_d;
      step_q   <= (state_d == ST_PRESS);
    end
  end

  assign step_o  = step_q;
  assign busy_o  = (state_q == ST_CHECK) || (state_q == ST_PRESS) ||
                   (state_q == ST_RELEASE);
  assign done_o  = (state_q == ST_DONE);
  assign err_o   = err_q;
  assign steps_o = steps_q;

endmodule

// File: tb/tb_color_stepper.sv
// Self-checking bench for color_stepper: a behavioural mixer closes the loop
// and expected press counts come from modular distance arithmetic.
module tb_color_stepper;

  localparam int N  = 8;
  localparam int P  = 16;
  localparam int R  = 16;
  localparam int N6 = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       go;
  logic [2:0] tgt;
  logic [2:0] mix;
  logic       step, busy, done, err;
  logic [3:0] steps;

  logic       go6;
  logic [2:0] tgt6, st6;
  logic       step6, busy6, done6, err6;
  logic [3:0] steps6;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  color_stepper u_dut (
    .clk(clk), .rst(rst), .go_i(go), .target_i(tgt), .state_i(mix),
    .step_o(step), .busy_o(busy), .done_o(done), .err_o(err), .steps_o(steps)
  );

  color_stepper #(.NUM_STATES(N6)) u_dut6 (
    .clk(clk), .rst(rst), .go_i(go6), .target_i(tgt6), .state_i(st6),
    .step_o(step6), .busy_o(busy6), .done_o(done6), .err_o(err6), .steps_o(steps6)
  );

  // Behavioural mixer: advances one state per rising edge of the button.
  logic       preset_req, dead, step_prev;
  logic [2:0] preset_val;
  always @(posedge clk) begin
    step_prev <= step;
    if (preset_req) mix <= preset_val;
    else if (!dead && step && !step_prev) mix <= 3'((int'(mix) + 1) % N);
  end

  // Pulse monitor: counts presses, checks widths and press-to-press spacing.
  logic mon_clr, mon_prev, any6;
  int   pulses, bad_width, bad_period, dones, cyc, last_rise, hi_len;
  always @(negedge clk) begin
    if (mon_clr) begin
      pulses <= 0; bad_width <= 0; bad_period <= 0; dones <= 0;
      cyc <= 0; last_rise <= 0; hi_len <= 0; mon_prev <= 1'b0; any6 <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (step && !mon_prev) begin
        pulses <= pulses + 1;
        if (pulses != 0 && (cyc - last_rise) != P + R + 1) bad_period <= bad_period + 1;
        last_rise <= cyc;
        hi_len    <= 1;
      end else if (step) begin
        hi_len <= hi_len + 1;
      end
      if (!step && mon_prev && hi_len != P) bad_width <= bad_width + 1;
      if (done) dones <= dones + 1;
      if (step6) any6 <= 1'b1;
      mon_prev <= step;
    end
  end

  function automatic int exp_presses(input int s, input int t, input int n);
    return (t - s + n) % n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preset_mixer(input int s, input bit d);
    dead       = d;
    preset_val = 3'(s);
    preset_req = 1'b1;
    mon_clr    = 1'b1;
    tick();
    preset_req = 1'b0;
    mon_clr    = 1'b0;
  endtask

  task automatic pulse_go(input logic [2:0] t);
    tgt = t;
    go  = 1'b1;
    tick();
    go  = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (step !== 1'b0)  begin bad++; $display("[TB] FAIL reset_step got=%0b want=0", step); end
    total++; if (busy !== 1'b0)  begin bad++; $display("[TB] FAIL reset_busy got=%0b want=0", busy); end
    total++; if (done !== 1'b0)  begin bad++; $display("[TB] FAIL reset_done got=%0b want=0", done); end
    total++; if (err !== 1'b0)   begin bad++; $display("[TB] FAIL reset_err got=%0b want=0", err); end
    total++; if (steps !== 4'd0) begin bad++; $display("[TB] FAIL reset_steps got=%0d want=0", steps); end
    tick();
  endtask

  task automatic run_and_check(input string name, input int s, input int t);
    bit to;
    int exp;
    exp = exp_presses(s, t, N);
    preset_mixer(s, 1'b0);
    pulse_go(3'(t));
    wait_idle(N * (P + R + 1) + 20, to);
    total++; if (to !== 1'b0)       begin bad++; $display("[TB] FAIL %s_timeout got=%0b want=0", name, to); end
    total++; if (done !== 1'b1)     begin bad++; $display("[TB] FAIL %s_done got=%0b want=1", name, done); end
    total++; if (err !== 1'b0)      begin bad++; $display("[TB] FAIL %s_err got=%0b want=0", name, err); end
    total++; if (steps !== 4'(exp)) begin bad++; $display("[TB] FAIL %s_steps got=%0d want=%0d", name, steps, exp); end
    tick();
    total++; if (pulses != exp)     begin bad++; $display("[TB] FAIL %s_pulses got=%0d want=%0d", name, pulses, exp); end
    total++; if (bad_width != 0)    begin bad++; $display("[TB] FAIL %s_width got=%0d want=0", name, bad_width); end
    total++; if (bad_period != 0)   begin bad++; $display("[TB] FAIL %s_period got=%0d want=0", name, bad_period); end
    total++; if (dones != 1)        begin bad++; $display("[TB] FAIL %s_dones got=%0d want=1", name, dones); end
    total++; if (mix !== 3'(t))     begin bad++; $display("[TB] FAIL %s_mixer got=%0d want=%0d", name, mix, t); end
  endtask

  task automatic test_basic();
    run_and_check("basic", 0, 3);
  endtask

  task automatic test_wrap();
    run_and_check("wrap", 6, 1);
  endtask

  task automatic test_already();
    preset_mixer(5, 1'b0);
    pulse_go(3'd5);
    @(negedge clk);
    total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("[TB] FAIL already_check busy=%0b done=%0b want busy=1 done=0", busy, done); end
    @(negedge clk);
    total++; if (done !== 1'b1)  begin bad++; $display("[TB] FAIL already_done got=%0b want=1", done); end
    total++; if (steps !== 4'd0) begin bad++; $display("[TB] FAIL already_steps got=%0d want=0", steps); end
    tick();
    total++; if (pulses != 0)    begin bad++; $display("[TB] FAIL already_pulses got=%0d want=0", pulses); end
  endtask

  task automatic test_dead();
    bit to;
    preset_mixer(0, 1'b1);
    pulse_go(3'd4);
    wait_idle(N * (P + R + 1) + 40, to);
    total++; if (to !== 1'b0)   begin bad++; $display("[TB] FAIL dead_timeout got=%0b want=0", to); end
    total++; if (err !== 1'b1)  begin bad++; $display("[TB] FAIL dead_err got=%0b want=1", err); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL dead_busy got=%0b want=0", busy); end
    tick();
    total++; if (pulses != N)   begin bad++; $display("[TB] FAIL dead_pulses got=%0d want=%0d", pulses, N); end
    total++; if (dones != 0)    begin bad++; $display("[TB] FAIL dead_dones got=%0d want=0", dones); end
    total++; if (err !== 1'b1)  begin bad++; $display("[TB] FAIL dead_sticky got=%0b want=1", err); end
    pulse_go(3'd0);
    @(negedge clk);
    total++; if (err !== 1'b0)  begin bad++; $display("[TB] FAIL dead_clear got=%0b want=0", err); end
    wait_idle(20, to);
    total++; if (to !== 1'b0 || done !== 1'b1) begin bad++; $display("[TB] FAIL dead_recover done=%0b timeout=%0b want done=1 timeout=0", done, to); end
    tick();
  endtask

  task automatic test_invalid();
    preset_mixer(0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      st6  = 3'd0;
      tgt6 = (k == 0) ? 3'd7 : 3'd6;
      go6  = 1'b1;
      tick();
      go6  = 1'b0;
      @(negedge clk);
      total++; if (err6 !== 1'b1)  begin bad++; $display("[TB] FAIL invalid%0d_err got=%0b want=1", k, err6); end
      total++; if (busy6 !== 1'b0) begin bad++; $display("[TB] FAIL invalid%0d_busy got=%0b want=0", k, busy6); end
      repeat (3) tick();
    end
    total++; if (any6 !== 1'b0) begin bad++; $display("[TB] FAIL invalid_step got=%0b want=0", any6); end
    st6  = 3'd5;
    tgt6 = 3'd5;
    go6  = 1'b1;
    tick();
    go6  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (done6 !== 1'b1 || err6 !== 1'b0) begin bad++; $display("[TB] FAIL invalid_top done=%0b err=%0b want done=1 err=0", done6, err6); end
    tick();
  endtask

  task automatic test_reset_midpress();
    bit seen;
    seen = 1'b0;
    preset_mixer(0, 1'b0);
    pulse_go(3'd5);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (step) begin
        seen = 1'b1;
        break;
      end
    end
    total++; if (seen !== 1'b1) begin bad++; $display("[TB] FAIL midpress_reach got=%0b want=1", seen); end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (step !== 1'b0)  begin bad++; $display("[TB] FAIL midpress_step got=%0b want=0", step); end
    total++; if (busy !== 1'b0)  begin bad++; $display("[TB] FAIL midpress_busy got=%0b want=0", busy); end
    total++; if (steps !== 4'd0) begin bad++; $display("[TB] FAIL midpress_steps got=%0d want=0", steps); end
    @(posedge clk);
    #1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    bit to;
    preset_mixer(0, 1'b0);
    pulse_go(3'd2);
    repeat (5) tick();
    tgt = 3'd6;
    go  = 1'b1;
    repeat (40) tick();
    go  = 1'b0;
    wait_idle(200, to);
    total++; if (to !== 1'b0 || done !== 1'b1) begin bad++; $display("[TB] FAIL ignore_done done=%0b timeout=%0b want done=1 timeout=0", done, to); end
    total++; if (steps !== 4'd2) begin bad++; $display("[TB] FAIL ignore_steps got=%0d want=2", steps); end
    total++; if (mix !== 3'd2)   begin bad++; $display("[TB] FAIL ignore_mixer got=%0d want=2", mix); end
    tick();
  endtask

  task automatic test_random();
    int s, t;
    for (int i = 0; i < 6; i++) begin
      s = int'($urandom_range(0, N - 1));
      t = int'($urandom_range(0, N - 1));
      run_and_check($sformatf("rand%0d", i), s, t);
    end
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; tgt = 3'd0;
    go6 = 1'b0; tgt6 = 3'd0; st6 = 3'd0;
    dead = 1'b0; preset_req = 1'b1; preset_val = 3'd0; mon_clr = 1'b1;
    repeat (3) tick();
    test_reset();
    rst = 1'b0;
    preset_req = 1'b0;
    mon_clr = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_wrap();
    test_already();
    test_dead();
    test_invalid();
    test_reset_midpress();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
